// File: rtl/dmem_mmio_pkg.sv
// Shared constants, register map and helpers for the data-side memory/MMIO responder.
package dmem_mmio_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam int unsigned TX_W           = 8;
    localparam int unsigned RAM_AW_DEF     = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    // Address bit that selects the peripheral block instead of RAM
    localparam int unsigned MMIO_BASE = 31;

    // Word offsets within the peripheral block (addr[3:2])
    typedef enum logic [1:0] {
        OFS_CYCLE = 2'd0,
        OFS_TCMP  = 2'd1,
        OFS_TSTAT = 2'd2,
        OFS_TX    = 2'd3
    } mmio_ofs_e;

    localparam int unsigned TSTAT_MATCH = 0;
    localparam int unsigned TSTAT_EN    = 1;
    localparam int unsigned TSTAT_OVF   = 2;

    function automatic logic [DATA_W-1:0] tstat_word(input logic match,
                                                     input logic en,
                                                     input logic ovf);
        logic [DATA_W-1:0] w;
        w              = '0;
        w[TSTAT_MATCH] = match;
        w[TSTAT_EN]    = en;
        w[TSTAT_OVF]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// Core data-memory bus plus transmit stream and interrupt, grouped for the responder.
interface dmem_mmio_if;
    import dmem_mmio_pkg::*;

    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [DATA_W-1:0] rdata;
    logic [TX_W-1:0]   tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              irq;

    modport master (
        output addr, wdata, we, tx_ready,
        input  rdata, tx_data, tx_valid, irq
    );

    modport slave (
        input  addr, wdata, we, tx_ready,
        output rdata, tx_data, tx_valid, irq
    );

endinterface

// File: rtl/dmem_mmio_tx_fifo.sv
// Byte transmit FIFO: push/pop with full judged on the pre-edge count, drop pulse on overflow.
module dmem_mmio_tx_fifo
    import dmem_mmio_pkg::*;
#(
    parameter  int unsigned DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic [TX_W-1:0] push_data_i,
    input  logic            pop_i,
    output logic [TX_W-1:0] head_c,
    output logic            valid_c,
    output logic            full_c,
    output logic            empty_c,
    output logic            drop_c,
    output logic [CW-1:0]   count_o
);

    logic [TX_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok_c, pop_ok_c;

    // Pointer/count update; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        full_c    = (count_q == CW'(DEPTH));
        empty_c   = (count_q == '0);
        push_ok_c = push_i && !full_c;
        pop_ok_c  = pop_i && !empty_c;
        drop_c    = push_i && full_c;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_ok_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d   = count_q + CW'(push_ok_c) - CW'(pop_ok_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Head is forced to zero when empty so stale storage never leaks out
    assign head_c  = empty_c ? '0 : mem_q[rd_ptr_q];
    assign valid_c = !empty_c;
    assign count_o = count_q;

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory responder: word RAM below 0x8000_0000, cycle counter/timer/TX FIFO above.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned RAM_AW     = RAM_AW_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    dmem_mmio_if.slave bus
);

    localparam int unsigned RAM_WORDS = 1 << RAM_AW;
    localparam int unsigned FIFO_CW   = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0]  ram_mem [RAM_WORDS];
    logic               is_mmio_c, ram_we_c, mmio_we_c, tstat_we_c, tcmp_we_c;
    mmio_ofs_e          ofs_c;
    logic [RAM_AW-1:0]  ram_idx_c;
    logic               unused_addr_c;

    logic [DATA_W-1:0]  cycle_q, cycle_d;
    logic [DATA_W-1:0]  tcmp_q, tcmp_d;
    logic               match_q, match_d;
    logic               en_q, en_d;
    logic               ovf_q, ovf_d;
    logic               irq_q, irq_d;

    logic               tx_push_c, tx_drop_c, tx_full_c, tx_empty_c, tx_valid_c;
    logic [TX_W-1:0]    tx_head_c;
    logic [FIFO_CW-1:0] tx_count_c;
    logic [DATA_W-1:0]  rdata_c;

    assign is_mmio_c     = bus.addr[MMIO_BASE];
    assign ofs_c         = mmio_ofs_e'(bus.addr[3:2]);
    assign ram_idx_c     = bus.addr[RAM_AW+1:2];
    assign ram_we_c      = bus.we && !is_mmio_c;
    assign mmio_we_c     = bus.we && is_mmio_c;
    assign tcmp_we_c     = mmio_we_c && (ofs_c == OFS_TCMP);
    assign tstat_we_c    = mmio_we_c && (ofs_c == OFS_TSTAT);
    assign tx_push_c     = mmio_we_c && (ofs_c == OFS_TX);
    assign unused_addr_c = ^{bus.addr[MMIO_BASE-1:RAM_AW+2], bus.addr[1:0]};

    always_ff @(posedge clk) begin
        if (ram_we_c) ram_mem[ram_idx_c] <= bus.wdata;
    end

    // Timer and status next state; sticky sets are applied last so they beat a same-cycle W1C
    always_comb begin
        cycle_d = cycle_q + DATA_W'(1);
        tcmp_d  = tcmp_q;
        match_d = match_q;
        en_d    = en_q;
        ovf_d   = ovf_q;
        if (tcmp_we_c) tcmp_d = bus.wdata;
        if (tstat_we_c) begin
            en_d = bus.wdata[TSTAT_EN];
            if (bus.wdata[TSTAT_MATCH]) match_d = 1'b0;
            if (bus.wdata[TSTAT_OVF])   ovf_d   = 1'b0;
        end
        if (en_q && (cycle_q == tcmp_q)) match_d = 1'b1;
        if (tx_drop_c)                   ovf_d   = 1'b1;
        irq_d = match_d && en_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            tcmp_q  <= '1;
            match_q <= 1'b0;
            en_q    <= 1'b0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            tcmp_q  <= tcmp_d;
            match_q <= match_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end

    dmem_mmio_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (tx_push_c),
        .push_data_i (bus.wdata[TX_W-1:0]),
        .pop_i       (bus.tx_ready),
        .head_c      (tx_head_c),
        .valid_c     (tx_valid_c),
        .full_c      (tx_full_c),
        .empty_c     (tx_empty_c),
        .drop_c      (tx_drop_c),
        .count_o     (tx_count_c)
    );

    // Same-cycle load data; CYCLE reads return the pre-edge value
    always_comb begin
        rdata_c = '0;
        if (!is_mmio_c) begin
            rdata_c = ram_mem[ram_idx_c];
        end else begin
            case (ofs_c)
                OFS_CYCLE: rdata_c = cycle_q;
                OFS_TCMP:  rdata_c = tcmp_q;
                OFS_TSTAT: rdata_c = tstat_word(match_q, en_q, ovf_q);
                OFS_TX:    rdata_c = DATA_W'({tx_count_c, tx_full_c, tx_empty_c});
                default:   rdata_c = '0;
            endcase
        end
    end

    assign bus.rdata    = rdata_c;
    assign bus.tx_data  = tx_head_c;
    assign bus.tx_valid = tx_valid_c;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: directed scenarios plus random traffic against a queue/array model.
module tb_dmem_mmio;
    import dmem_mmio_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_mmio_if bus ();

    dmem_mmio #(.RAM_AW(8), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    logic [31:0] m_ram    [256];
    bit          m_ram_ok [256];
    logic [31:0] m_cycle, m_tcmp;
    bit          m_match, m_en, m_ovf, m_irq;
    logic [7:0]  m_fifo [$];

    // Scoreboard queues
    logic [31:0] rd_exp [$];
    string       rd_nm  [$];
    logic [9:0]  ctl_exp [$];
    logic [7:0]  txq [$];

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_cycle = '0;
        m_tcmp  = 32'hFFFF_FFFF;
        m_match = 1'b0;
        m_en    = 1'b0;
        m_ovf   = 1'b0;
        m_irq   = 1'b0;
        m_fifo.delete();
        txq.delete();
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
        int n;
        n     = m_fifo.size();
        known = 1'b1;
        if (!a[31]) begin
            known = m_ram_ok[a[9:2]];
            return m_ram[a[9:2]];
        end
        case (a[3:2])
            2'd0:    return m_cycle;
            2'd1:    return m_tcmp;
            2'd2:    return {29'd0, m_ovf, m_en, m_match};
            default: return {27'd0, 3'(n), (n == 4), (n == 0)};
        endcase
    endfunction

    // Advance the model by one clock edge with the inputs that were applied
    function automatic void model_step(input logic [31:0] a, input logic [31:0] d,
                                       input logic w, input logic rdy);
        bit mm, tst_w, push, full, setm, nm, ne, no;
        mm    = a[31];
        tst_w = w && mm && (a[3:2] == 2'd2);
        push  = w && mm && (a[3:2] == 2'd3);
        full  = (m_fifo.size() == 4);
        setm  = m_en && (m_cycle == m_tcmp);
        nm    = setm ? 1'b1 : ((tst_w && d[0]) ? 1'b0 : m_match);
        ne    = tst_w ? d[1] : m_en;
        no    = (push && full) ? 1'b1 : ((tst_w && d[2]) ? 1'b0 : m_ovf);
        if (w && mm && (a[3:2] == 2'd1)) m_tcmp = d;
        if (w && !mm) begin
            m_ram[a[9:2]]    = d;
            m_ram_ok[a[9:2]] = 1'b1;
        end
        if (rdy && (m_fifo.size() > 0)) void'(m_fifo.pop_front());
        if (push && !full) begin
            m_fifo.push_back(d[7:0]);
            txq.push_back(d[7:0]);
        end
        m_match = nm;
        m_en    = ne;
        m_ovf   = no;
        m_irq   = nm & ne;
        m_cycle = m_cycle + 32'd1;
    endfunction

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic rdy, input string nm);
        bit          known;
        logic [31:0] e;
        logic [7:0]  hd;
        bus.addr     = a;
        bus.wdata    = d;
        bus.we       = w;
        bus.tx_ready = rdy;
        e = model_read(a, known);
        if (known) begin
            rd_exp.push_back(e);
            rd_nm.push_back(nm);
        end
        hd = (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
        ctl_exp.push_back({m_irq, (m_fifo.size() != 0), hd});
        @(posedge clk);
        model_step(a, d, w, rdy);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        step(a, d, 1'b1, rdy, "rdata_on_write");
    endtask

    task automatic rd(input logic [31:0] a, input string nm, input logic rdy);
        step(a, 32'h0, 1'b0, rdy, nm);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(32'h8000_0000, 32'h0, 1'b0, rdy, "cycle_idle");
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations
    initial begin
        logic [9:0] c;
        forever begin
            @(negedge clk);
            if (rd_exp.size() > 0) check(rd_nm.pop_front(), bus.rdata, rd_exp.pop_front());
            if (ctl_exp.size() > 0) begin
                c = ctl_exp.pop_front();
                check("irq", 32'(bus.irq), 32'(c[9]));
                check("tx_valid", 32'(bus.tx_valid), 32'(c[8]));
                check("tx_data", 32'(bus.tx_data), 32'(c[7:0]));
            end
            if (rst_n && bus.tx_valid && bus.tx_ready) begin
                if (txq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_stream: byte 0x%02h emitted, none expected", bus.tx_data);
                end else begin
                    check("tx_stream", 32'(bus.tx_data), 32'(txq.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached with checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned sel;
        logic [31:0] a, d;
        logic        r;

        rst_n        = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.we       = 1'b0;
        bus.tx_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        rd(32'h8000_0004, "tcmp_reset", 1'b0);
        rd(32'h8000_0008, "tstat_reset", 1'b0);
        rd(32'h8000_000C, "txstat_reset", 1'b0);
        rd(32'h8000_0000, "cycle_reset", 1'b0);

        // RAM write-then-read and aliasing
        wr(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        rd(32'h0000_0010, "ram_rd", 1'b0);
        rd(32'h0000_0410, "ram_alias", 1'b0);
        rd(32'h0000_0013, "ram_low_bits", 1'b0);
        check("ram_const", bus.rdata, 32'hDEAD_BEEF);

        // Cycle counter, write ignored
        idle(100, 1'b0);
        rd(32'h8000_0000, "cycle_100", 1'b0);
        wr(32'h8000_0000, 32'h0000_1234, 1'b0);
        rd(32'h8000_0000, "cycle_after_wr", 1'b0);
        rd(32'hFFFF_FFF0, "cycle_alias", 1'b0);

        // Timer match, irq, W1C clear keeping EN
        wr(32'h8000_0004, m_cycle + 32'd6, 1'b0);
        wr(32'h8000_0008, 32'h2, 1'b0);
        idle(8, 1'b0);
        rd(32'h8000_0008, "tstat_match", 1'b0);
        wr(32'h8000_0008, 32'h3, 1'b0);
        idle(2, 1'b0);
        rd(32'h8000_0008, "tstat_cleared", 1'b0);
        wr(32'h8000_0008, 32'h0, 1'b0);

        // Overflow: five pushes into a four-deep FIFO with consumer stalled
        for (int i = 0; i < 5; i++) wr(32'h8000_000C, 32'h41 + 32'(i), 1'b0);
        rd(32'h8000_000C, "txstat_full", 1'b0);
        rd(32'h8000_0008, "tstat_ovf", 1'b0);
        idle(6, 1'b1);
        rd(32'h8000_000C, "txstat_drained", 1'b0);

        // Simultaneous push and pop with two queued
        wr(32'h8000_0008, 32'h4, 1'b0);
        wr(32'h8000_000C, 32'h51, 1'b0);
        wr(32'h8000_000C, 32'h52, 1'b0);
        wr(32'h8000_000C, 32'h53, 1'b1);
        rd(32'h8000_000C, "txstat_push_pop", 1'b0);
        idle(4, 1'b1);

        // Push while full with a pop in the same cycle
        for (int i = 0; i < 4; i++) wr(32'h8000_000C, 32'h60 + 32'(i), 1'b0);
        wr(32'h8000_000C, 32'h6F, 1'b1);
        rd(32'h8000_0008, "tstat_ovf_full_pop", 1'b0);
        rd(32'h8000_000C, "txstat_after_full_pop", 1'b0);
        idle(5, 1'b1);

        // Reset mid-transfer with irq high and bytes queued
        wr(32'h8000_0004, m_cycle + 32'd3, 1'b0);
        wr(32'h8000_0008, 32'h2, 1'b0);
        idle(5, 1'b0);
        for (int i = 0; i < 3; i++) wr(32'h8000_000C, 32'h70 + 32'(i), 1'b0);
        check("irq_before_reset", 32'(bus.irq), 32'(1));
        bus.we = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("tx_valid_async_reset", 32'(bus.tx_valid), 32'(0));
        check("irq_async_reset", 32'(bus.irq), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        rd(32'h8000_0004, "tcmp_after_reset", 1'b0);
        rd(32'h8000_000C, "txstat_after_reset", 1'b0);
        rd(32'h8000_0008, "tstat_after_reset", 1'b0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            sel = $urandom_range(0, 11);
            r   = ($urandom_range(0, 2) == 0);
            d   = $urandom;
            case (sel)
                0, 1, 2: wr({1'b0, 21'($urandom), 4'd0, 4'($urandom), 2'($urandom)}, d, r);
                3, 4:    rd({1'b0, 21'($urandom), 4'd0, 4'($urandom), 2'($urandom)}, "rand_ram", r);
                5:       rd({1'b1, 27'($urandom), 2'($urandom), 2'($urandom)}, "rand_mmio", r);
                6, 7:    wr({1'b1, 27'($urandom), 2'd3, 2'($urandom)}, d, r);
                8:       wr({1'b1, 27'($urandom), 2'd2, 2'($urandom)}, d, r);
                9:       wr({1'b1, 27'($urandom), 2'd1, 2'($urandom)},
                            m_cycle + 32'($urandom_range(0, 6)), r);
                10:      wr({1'b1, 27'($urandom), 2'd0, 2'($urandom)}, d, r);
                default: idle(1, r);
            endcase
        end
        idle(8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
